// File: rtl/serial_add_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_subtractor
//  Brief    : Multi-cycle add/subtract unit, CHUNK bits per clock, LSB first,
//             with carry/borrow out, signed overflow and start/ready/done.
//  Revision : 1.0  initial release
// ============================================================================
module serial_add_subtractor #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int            NCYC = WIDTH / CHUNK;
   localparam int            CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("serial_add_subtractor: CHUNK must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic             r_sub;
   logic             r_cy;
   logic             r_cout;
   logic             r_ovf;
   logic [CW-1:0]    r_cnt;

   logic [CHUNK-1:0] w_ca;
   logic [CHUNK-1:0] w_cb;
   logic [CHUNK-1:0] w_sum;
   logic [CHUNK:0]   w_c;
   logic [WIDTH-1:0] w_full;
   logic             w_last;
   logic             w_ovf;

   assign w_ca   = r_a[r_cnt*CHUNK +: CHUNK];
   assign w_cb   = r_b[r_cnt*CHUNK +: CHUNK];
   assign w_last = (r_cnt == LAST);

   // One ripple chain serves both modes; only the carry/borrow term differs.
   always_comb begin
      w_c    = '0;
      w_sum  = '0;
      w_c[0] = r_cy;
      for (int i = 0; i < CHUNK; i++) begin
         w_sum[i] = w_ca[i] ^ w_cb[i] ^ w_c[i];
         if (r_sub)
            w_c[i+1] = (~w_ca[i] & w_cb[i]) | (~(w_ca[i] ^ w_cb[i]) & w_c[i]);
         else
            w_c[i+1] = (w_ca[i] & w_cb[i]) | ((w_ca[i] ^ w_cb[i]) & w_c[i]);
      end
   end

   always_comb begin
      w_full = r_acc;
      w_full[(NCYC-1)*CHUNK +: CHUNK] = w_sum;
   end

   assign w_ovf = r_sub ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]))
                        : ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[CHUNK-1] != r_a[WIDTH-1]));

   always_comb begin
      w_next = r_state;
      ready  = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (start) w_next = RUN;
         end
         RUN: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_sub    <= 1'b0;
         r_cy     <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a   <= A;
                  r_b   <= B;
                  r_sub <= sub;
                  r_cnt <= '0;
                  r_cy  <= 1'b0;
               end
            end
            RUN: begin
               r_acc[r_cnt*CHUNK +: CHUNK] <= w_sum;
               r_cy <= w_c[CHUNK];
               if (!w_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  // Visible outputs only move here, so they hold through the next op.
                  r_result <= w_full;
                  r_cout   <= w_c[CHUNK];
                  r_ovf    <= w_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_subtractor
//  Brief    : Scoreboard bench: 32/4 directed ops plus 8-bit CHUNK sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_add_subtractor;

   typedef struct packed {
      logic [31:0] r;
      logic        c;
      logic        o;
      logic [31:0] t;
   } exp_t;

   // {sub, A, B, result, cout, ovf} for WIDTH=8
   localparam logic [26:0] TV [10] = '{
      {1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1},
      {1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0},
      {1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1},
      {1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
      {1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
      {1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1},
      {1'b1, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0},
      {1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0},
      {1'b1, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
      {1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0}
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic sweep_go = 1'b0;

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [9:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
      logic [8:0] u;
      int         sr;
      logic       o;
      u  = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
      sr = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
      o  = (sr > 127) || (sr < -128);
      return {u[8], o, u[7:0]};
   endfunction

   // ---------------- 32-bit, CHUNK=4 instance ----------------
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        ready;
   logic        done;
   logic [31:0] result;
   logic        cout;
   logic        ovf;
   exp_t        q32[$];

   serial_add_subtractor #(.WIDTH(32), .CHUNK(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
      .ready(ready), .done(done), .result(result), .cout(cout), .ovf(ovf)
   );

   task automatic issue32(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic push, input logic [31:0] er, input logic ec, input logic eo);
      int   n;
      exp_t e;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (ready !== 1'b1) fail("ready_timeout32");
      start = 1'b1; sub = s; A = x; B = y;
      e.r = er; e.c = ec; e.o = eo; e.t = cyc;
      if (push) q32.push_back(e);
      @(negedge clk);
      start = 1'b0; sub = ~s; A = '1; B = '1;
   endtask

   task automatic wait_done32();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) fail("done_timeout32");
   endtask

   initial begin : mon32
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (q32.size() == 0) fail("unexpected_done32");
            else begin
               e = q32.pop_front();
               check("result32", result, e.r);
               check("cout32", cout, e.c);
               check("ovf32", ovf, e.o);
               check("latency32", cyc - e.t, 9);
            end
         end
      end
   end

   // ---------------- 8-bit CHUNK sweep ----------------
   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int CH = (g == 0) ? 8 : ((g == 1) ? 2 : 1);
      localparam int NC = 8 / CH;
      logic       st, sb, rdy, dn, co, ov;
      logic       fin = 1'b0;
      logic [7:0] xa, xb, res;
      exp_t       q[$];

      serial_add_subtractor #(.WIDTH(8), .CHUNK(CH)) u_dut (
         .clk(clk), .rst(rst), .start(st), .sub(sb), .A(xa), .B(xb),
         .ready(rdy), .done(dn), .result(res), .cout(co), .ovf(ov)
      );

      task automatic iss(input logic s, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic eo);
         int   n;
         exp_t e;
         n = 0;
         while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (rdy !== 1'b1) fail($sformatf("ready_timeout8_c%0d", CH));
         st = 1'b1; sb = s; xa = x; xb = y;
         e.r = {24'b0, er}; e.c = ec; e.o = eo; e.t = cyc;
         q.push_back(e);
         @(negedge clk);
         st = 1'b0; xa = ~x; xb = ~y;
      endtask

      initial begin : drv
         logic [26:0] v;
         logic [9:0]  m;
         logic        s;
         logic [7:0]  x, y;
         int          n;
         st = 1'b0; sb = 1'b0; xa = '0; xb = '0;
         wait (sweep_go);
         @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            v = TV[i];
            iss(v[26], v[25:18], v[17:10], v[9:2], v[1], v[0]);
         end
         for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            x = 8'($urandom);
            y = 8'($urandom);
            m = model(s, x, y);
            iss(s, x, y, m[7:0], m[9], m[8]);
         end
         n = 0;
         while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check($sformatf("drain8_c%0d", CH), 64'(q.size()), 0);
         fin = 1'b1;
      end

      initial begin : mon
         exp_t e;
         forever begin
            @(negedge clk);
            if (dn === 1'b1) begin
               if (q.size() == 0) fail($sformatf("unexpected_done8_c%0d", CH));
               else begin
                  e = q.pop_front();
                  check($sformatf("result8_c%0d", CH), {24'b0, res}, e.r);
                  check($sformatf("cout8_c%0d", CH), co, e.c);
                  check($sformatf("ovf8_c%0d", CH), ov, e.o);
                  check($sformatf("latency8_c%0d", CH), cyc - e.t, NC + 1);
               end
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      repeat (3) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_done", done, 0);
      check("rst_ready", ready, 1);
      rst = 1'b0;
      @(negedge clk);

      issue32(1'b1, 32'd5, 32'd3, 1'b1, 32'd2, 1'b0, 1'b0);
      wait_done32();
      @(negedge clk);
      check("ready_after_done", ready, 1);
      check("done_one_cycle", done, 0);
      check("result_hold", result, 32'd2);

      issue32(1'b1, 32'h0000_0000, 32'h1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      issue32(1'b1, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
      issue32(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      issue32(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
      issue32(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_6789, 1'b0, 1'b0);
      issue32(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);

      // Start pulse during the third RUN cycle must be ignored.
      issue32(1'b1, 32'd100, 32'd40, 1'b1, 32'd60, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; sub = 1'b0; A = 32'd1; B = 32'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done32();
      @(negedge clk);

      // Asynchronous reset in the middle of RUN abandons the op.
      issue32(1'b0, 32'd7, 32'd8, 1'b0, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_result", result, 0);
      check("midrst_cout", cout, 0);
      check("midrst_ovf", ovf, 0);
      check("midrst_ready", ready, 1);
      check("midrst_done", done, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("ready_after_rst", ready, 1);
      issue32(1'b0, 32'd1, 32'd2, 1'b1, 32'd3, 1'b0, 1'b0);

      n = 0;
      while (q32.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain32", 64'(q32.size()), 0);

      sweep_go = 1'b1;
      n = 0;
      while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      if (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin)) fail("sweep_timeout");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/serial_add_subtractor.md
Name: serial_add_subtractor

Overview:
- Multi-cycle, parametrised add/subtract unit. Processes CHUNK bits per clock through a ripple chain of full-adder/full-subtractor cells, LSB chunk first.
- Successor to the fixed-width combinational subtractor. Adds selectable add/subtract mode, carry/borrow out, signed overflow, and a start/ready/done handshake.
- Trades latency for area on wide datapaths. Sits between operand registers and the ALU result mux.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 4, bits processed per clock. Must divide WIDTH exactly; 1 <= CHUNK <= WIDTH.
- NCYC, WIDTH/CHUNK, derived (localparam). Number of compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation. Accepted only while ready=1.
- sub  input  1  mode: 0 = A+B, 1 = A-B. Sampled with start.
- A  input  WIDTH  first operand. Sampled with start.
- B  input  WIDTH  second operand. Sampled with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse: result, cout and ovf are valid.
- result  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
- cout  output  1  add: carry out of MSB. Sub: borrow out of MSB (1 iff A<B unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values (immediate, asynchronous, applied in any state including mid-RUN):
  - result=0, cout=0, ovf=0, done=0, ready=1.
  - Internal operand shift registers, chunk counter and carry/borrow flop cleared.
  - An operation in flight is abandoned; no done is produced for it.
- IDLE:
  - ready=1.
  - On an edge with start=1: latch A, B and sub; clear chunk counter; clear the carry/borrow flop; go to RUN.
  - start=0: stay in IDLE.
- RUN (ready=0):
  - Each edge processes chunk k = counter, i.e. bits [k*CHUNK +: CHUNK].
  - Computes the chunk from the latched operands and the carry/borrow flop:
    - Add: bitwise full-adder ripple.
    - Sub: bitwise full-subtractor ripple, diff = a^b^bin, borrow propagation.
  - Writes the chunk into the result shift register and stores the chunk's carry/borrow out in the flop.
  - Counter increments.
  - On the edge processing chunk NCYC-1: go to DONE and register the final cout and ovf.
- DONE:
  - done=1 for exactly one cycle; ready=0.
  - Next edge returns to IDLE.
- Latency:
  - start accepted on edge E; done is high during the cycle after edge E+NCYC.
  - Next start is accepted no earlier than edge E+NCYC+2.
  - CHUNK=WIDTH gives NCYC=1.
- start while ready=0 (RUN or DONE): ignored. Latched operands are not disturbed.
- Result hold:
  - result, cout and ovf stay stable from DONE until the edge that accepts the next start.
  - The result register is internal during RUN. The result output must not change until DONE: use a separate output register loaded at the DONE transition, or an equivalent.
- ovf rule, with sA, sB = operand MSBs and sR = result MSB:
  - add: ovf = (sA==sB) && (sR!=sA).
  - sub: ovf = (sA!=sB) && (sR!=sA).
- Arithmetic:
  - All widths are exactly WIDTH; no sign extension.
  - Wrap-around is modulo 2^WIDTH and is reported via cout/ovf, never saturated.
- The chunk counter is sized for NCYC and wraps only via the IDLE reload.
- Elaboration check: WIDTH%CHUNK != 0 must be rejected (error) at elaboration.

Test Plan:
- WIDTH=32, CHUNK=4, sub=1, A=5, B=3, start one cycle -> after 8 compute edges: done pulse, result=2, cout=0, ovf=0; ready high on the following cycle.
- sub=1, A=0, B=1 -> result=0xFFFFFFFF, cout(borrow)=1, ovf=0. Then sub=1, A=0x80000000, B=1 -> result=0x7FFFFFFF, cout=0, ovf=1.
- sub=0, A=0xFFFFFFFF, B=1 -> result=0, cout=1, ovf=0. Then sub=0, A=0x7FFFFFFF, B=1 -> result=0x80000000, cout=0, ovf=1.
- Start with A=100, B=40, sub=1. Pulse start with A=1, B=1 during the 3rd RUN cycle -> ignored; done gives 60. Assert rst asynchronously mid-RUN on a second op -> outputs 0, ready=1 immediately, no done.
- Parameter sweep: WIDTH=8 with CHUNK=8, 2 and 1 (1, 4 and 8 cycles). Random 1000 ops per config, including back-to-back starts issued as soon as ready=1 -> results match the A±B reference model, done latency = NCYC+1 cycles from the start edge.
